// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the completer state encoding.
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic {
    APB_S_IDLE   = 1'b0,
    APB_S_ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/apb_byte_merge.sv
// Byte-lane merge: each strobed lane takes the new data, the others keep the old data.
module apb_byte_merge
  import apb_pkg::*;
(
  input  logic [APB_DATA_W-1:0] old_data,
  input  logic [APB_DATA_W-1:0] new_data,
  input  logic [APB_STRB_W-1:0] strb,
  output logic [APB_DATA_W-1:0] merged
);

  genvar gi;
  generate
    for (gi = 0; gi < APB_STRB_W; gi++) begin : g_lane
      // One 8-bit mux per byte lane
      assign merged[8*gi +: 8] = strb[gi] ? new_data[8*gi +: 8] : old_data[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of 32-bit registers, wait states, byte strobes and error responses.
// The top register is a read-only ID; its storage slot is never written and reads as zero on reg_out.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [31:0]                PADDR,
  input  logic [APB_DATA_W-1:0]      PWDATA,
  input  logic [APB_STRB_W-1:0]      PSTRB,
  input  logic [2:0]                 PPROT,
  output logic                       PREADY,
  output logic [APB_DATA_W-1:0]      PRDATA,
  output logic                       PSLVERR,
  output logic [32*NUM_REGS-1:0]     reg_out,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int MAX_REGS = 16;

  apb_state_e            state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic [APB_DATA_W-1:0] regs_reg [MAX_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_reg;

  logic [3:0]            idx;
  logic                  oor;
  logic                  ro;
  logic                  complete;
  logic                  commit_wr;
  logic [APB_DATA_W-1:0] rd_word;
  logic [APB_DATA_W-1:0] merged_data;
  logic                  unused_bits;

  // Protection bits and the byte offset carry no meaning for this register bank
  assign unused_bits = ^{PPROT, PADDR[1:0]};

  assign idx     = PADDR[5:2];
  assign oor     = (PADDR[31:2] >= 30'(NUM_REGS));
  assign ro      = (idx == 4'(NUM_REGS - 1));
  assign rd_word = ro ? ID_VALUE : regs_reg[idx];

  apb_byte_merge u_merge (
    .old_data (regs_reg[idx]),
    .new_data (PWDATA),
    .strb     (PSTRB),
    .merged   (merged_data)
  );

  // State and wait counter; reset aborts any transfer in flight
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg <= APB_S_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state, wait countdown and the combinational response lane
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    PREADY     = 1'b0;
    complete   = 1'b0;
    commit_wr  = 1'b0;
    PRDATA     = '0;
    PSLVERR    = 1'b0;
    case (state_reg)
      APB_S_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_next = APB_S_ACCESS;
          cnt_next   = 4'(WAIT_STATES);
        end
      end
      APB_S_ACCESS: begin
        PREADY = (cnt_reg == 4'd0);
        if (!PSEL) begin
          state_next = APB_S_IDLE;
        end else if (!PENABLE) begin
          cnt_next = 4'(WAIT_STATES);
        end else if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          state_next = APB_S_IDLE;
          complete   = 1'b1;
        end
      end
      default: state_next = APB_S_IDLE;
    endcase
    if (complete) begin
      if (PWRITE) begin
        commit_wr = !oor && !ro;
        PSLVERR   = oor || ro;
      end else begin
        PRDATA  = oor ? '0 : rd_word;
        PSLVERR = oor;
      end
    end
  end

  // Register bank update; only writable slots below the ID register can be selected
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < MAX_REGS; i++) regs_reg[i] <= '0;
    end else if (commit_wr) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (idx == 4'(i)) regs_reg[i] <= merged_data;
      end
    end
  end

  // One-cycle write strobe aligned with the updated register contents
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_pulse_reg <= '0;
    end else begin
      wr_pulse_reg <= commit_wr ? (NUM_REGS'(1) << idx) : '0;
    end
  end

  assign wr_pulse = wr_pulse_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_out
      assign reg_out[32*gi +: 32] = regs_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: a zero-wait instance and a two-wait-state instance share the bus signals.
module tb_apb_slave_regfile;

  logic         PCLK = 1'b0;
  logic         PRESET = 1'b1;
  logic         psel0 = 1'b0;
  logic         psel1 = 1'b0;
  logic         penable = 1'b0;
  logic         pwrite = 1'b0;
  logic [31:0]  paddr = '0;
  logic [31:0]  pwdata = '0;
  logic [3:0]   pstrb = '0;
  logic [2:0]   pprot = '0;

  logic         pready0, pready1;
  logic [31:0]  prdata0, prdata1;
  logic         pslverr0, pslverr1;
  logic [511:0] reg_out0, reg_out1;
  logic [15:0]  wr_pulse0, wr_pulse1;

  int           checks = 0;
  int           failures = 0;
  logic [7:0]   ready_hist = '0;

  always #5 PCLK = ~PCLK;

  apb_slave_regfile #(.NUM_REGS(16), .WAIT_STATES(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0),
    .reg_out(reg_out0), .wr_pulse(wr_pulse0)
  );

  apb_slave_regfile #(.NUM_REGS(16), .WAIT_STATES(2)) dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PREADY(pready1), .PRDATA(prdata1), .PSLVERR(pslverr1),
    .reg_out(reg_out1), .wr_pulse(wr_pulse1)
  );

  // One full APB transfer on the selected instance; returns at the negedge of the completion cycle
  task automatic xfer(input bit which, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rdata, output logic err, output int cycles);
    bit   done;
    logic rdy;
    @(posedge PCLK); #1;
    psel0 = !which; psel1 = which; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    cycles = 1; done = 1'b0; rdata = '0; err = 1'b0;
    @(posedge PCLK); #1;
    penable = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      cycles++;
      @(negedge PCLK);
      rdy = which ? pready1 : pready0;
      ready_hist = {ready_hist[6:0], rdy};
      if (rdy) begin
        rdata = which ? prdata1 : prdata0;
        err   = which ? pslverr1 : pslverr0;
        done  = 1'b1;
      end else begin
        @(posedge PCLK); #1;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL xfer_timeout addr=%h got no PREADY, required PREADY within 20 cycles", addr);
    end
    $display("xfer dut%0d %s addr=%h wdata=%h strb=%h rdata=%h err=%0d cycles=%0d",
             which, wr ? "WR" : "RD", addr, data, strb, rdata, err, cycles);
  endtask

  task automatic idle();
    @(posedge PCLK); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pstrb = '0;
    @(negedge PCLK);
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int cyc;
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    checks++; if (reg_out0 !== '0) begin failures++; $display("FAIL reset_reg_out got=%h required=0", reg_out0); end
    checks++; if (wr_pulse0 !== 16'h0) begin failures++; $display("FAIL reset_wr_pulse got=%h required=0", wr_pulse0); end
    checks++; if (pready0 !== 1'b0 || pslverr0 !== 1'b0 || prdata0 !== 32'h0) begin
      failures++; $display("FAIL reset_outputs got pready=%b pslverr=%b prdata=%h required 0/0/0", pready0, pslverr0, prdata0);
    end
    xfer(1'b0, 1'b0, 32'h00, '0, 4'h0, rd, err, cyc);
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL reset_read_00 got=%h err=%b required=00000000 err=0", rd, err); end
    xfer(1'b0, 1'b0, 32'h3C, '0, 4'h0, rd, err, cyc);
    checks++; if (rd !== 32'hA9B00001 || err !== 1'b0) begin failures++; $display("FAIL reset_read_id got=%h err=%b required=a9b00001 err=0", rd, err); end
    checks++; if (cyc !== 2) begin failures++; $display("FAIL zero_wait_cycles got=%0d required=2", cyc); end
    idle();
  endtask

  task automatic test_byte_strobe();
    logic [31:0] rd; logic err; int cyc;
    xfer(1'b0, 1'b1, 32'h08, 32'h11223344, 4'hF, rd, err, cyc);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL strb_write1_err got=%b required=0", err); end
    idle();
    checks++; if (wr_pulse0 !== 16'h0004) begin failures++; $display("FAIL strb_pulse1 got=%h required=0004", wr_pulse0); end
    checks++; if (reg_out0[64 +: 32] !== 32'h11223344) begin failures++; $display("FAIL strb_reg_out1 got=%h required=11223344", reg_out0[64 +: 32]); end
    idle();
    checks++; if (wr_pulse0 !== 16'h0) begin failures++; $display("FAIL strb_pulse1_single got=%h required=0000", wr_pulse0); end
    xfer(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 4'b0101, rd, err, cyc);
    idle();
    checks++; if (wr_pulse0 !== 16'h0004) begin failures++; $display("FAIL strb_pulse2 got=%h required=0004", wr_pulse0); end
    idle();
    checks++; if (wr_pulse0 !== 16'h0) begin failures++; $display("FAIL strb_pulse2_single got=%h required=0000", wr_pulse0); end
    xfer(1'b0, 1'b0, 32'h08, '0, 4'h0, rd, err, cyc);
    checks++; if (rd !== 32'h11AD33EF) begin failures++; $display("FAIL strb_readback got=%h required=11ad33ef", rd); end
    // Empty strobe: register holds, no error, pulse still fires
    xfer(1'b0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, rd, err, cyc);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL strb_zero_err got=%b required=0", err); end
    idle();
    checks++; if (wr_pulse0 !== 16'h0004) begin failures++; $display("FAIL strb_zero_pulse got=%h required=0004", wr_pulse0); end
    checks++; if (reg_out0[64 +: 32] !== 32'h11AD33EF) begin failures++; $display("FAIL strb_zero_hold got=%h required=11ad33ef", reg_out0[64 +: 32]); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int cyc;
    xfer(1'b1, 1'b1, 32'h04, 32'h0BADF00D, 4'hF, rd, err, cyc);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL ws_write_cycles got=%0d required=4", cyc); end
    xfer(1'b1, 1'b0, 32'h04, '0, 4'h0, rd, err, cyc);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL ws_read_cycles got=%0d required=4", cyc); end
    checks++; if (ready_hist[2:0] !== 3'b001) begin failures++; $display("FAIL ws_pready_pattern got=%b required=001", ready_hist[2:0]); end
    checks++; if (rd !== 32'h0BADF00D || err !== 1'b0) begin failures++; $display("FAIL ws_read_data got=%h err=%b required=0badf00d err=0", rd, err); end
    idle();
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int cyc;
    xfer(1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, rd, err, cyc);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_write_oor got=%b required=1", err); end
    idle();
    checks++; if (wr_pulse0 !== 16'h0) begin failures++; $display("FAIL err_write_oor_pulse got=%h required=0000", wr_pulse0); end
    xfer(1'b0, 1'b0, 32'h40, '0, 4'h0, rd, err, cyc);
    checks++; if (rd !== 32'h0 || err !== 1'b1) begin failures++; $display("FAIL err_read_oor got=%h err=%b required=00000000 err=1", rd, err); end
    xfer(1'b0, 1'b1, 32'h3C, 32'h12345678, 4'hF, rd, err, cyc);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_write_ro got=%b required=1", err); end
    idle();
    checks++; if (wr_pulse0 !== 16'h0) begin failures++; $display("FAIL err_write_ro_pulse got=%h required=0000", wr_pulse0); end
    xfer(1'b0, 1'b0, 32'h3C, '0, 4'h0, rd, err, cyc);
    checks++; if (rd !== 32'hA9B00001 || err !== 1'b0) begin failures++; $display("FAIL err_ro_readback got=%h err=%b required=a9b00001 err=0", rd, err); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int cyc;
    xfer(1'b0, 1'b1, 32'h0C, 32'hAAAA0003, 4'hF, rd, err, cyc);
    xfer(1'b0, 1'b1, 32'h10, 32'hAAAA0004, 4'hF, rd, err, cyc);
    xfer(1'b0, 1'b1, 32'h14, 32'hAAAA0005, 4'hF, rd, err, cyc);
    // Read straight after the last write, no idle gap
    xfer(1'b0, 1'b0, 32'h14, '0, 4'h0, rd, err, cyc);
    checks++; if (rd !== 32'hAAAA0005) begin failures++; $display("FAIL b2b_raw_read got=%h required=aaaa0005", rd); end
    xfer(1'b0, 1'b0, 32'h0C, '0, 4'h0, rd, err, cyc);
    checks++; if (rd !== 32'hAAAA0003) begin failures++; $display("FAIL b2b_reg3 got=%h required=aaaa0003", rd); end
    xfer(1'b0, 1'b0, 32'h10, '0, 4'h0, rd, err, cyc);
    checks++; if (rd !== 32'hAAAA0004) begin failures++; $display("FAIL b2b_reg4 got=%h required=aaaa0004", rd); end
    idle();
  endtask

  task automatic test_psel_abort();
    @(posedge PCLK); #1;
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1C; pwdata = 32'h00000055; pstrb = 4'hF;
    @(posedge PCLK); #1;
    psel0 = 1'b0; penable = 1'b1;
    @(negedge PCLK);
    checks++; if (pslverr0 !== 1'b0) begin failures++; $display("FAIL abort_pslverr got=%b required=0", pslverr0); end
    @(posedge PCLK); #1;
    penable = 1'b0;
    @(negedge PCLK);
    checks++; if (wr_pulse0 !== 16'h0) begin failures++; $display("FAIL abort_pulse got=%h required=0000", wr_pulse0); end
    checks++; if (reg_out0[224 +: 32] !== 32'h0) begin failures++; $display("FAIL abort_reg7 got=%h required=00000000", reg_out0[224 +: 32]); end
    checks++; if (pready0 !== 1'b0) begin failures++; $display("FAIL abort_idle_pready got=%b required=0", pready0); end
    $display("xfer dut0 WR addr=0000001c aborted by PSEL drop");
  endtask

  task automatic test_reset_abort();
    @(posedge PCLK); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    checks++; if (pready1 !== 1'b0) begin failures++; $display("FAIL rst_abort_wait1 got=%b required=0", pready1); end
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    checks++; if (pready1 !== 1'b0) begin failures++; $display("FAIL rst_abort_idle_pready got=%b required=0", pready1); end
    @(posedge PCLK); #1;
    psel1 = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    checks++; if (wr_pulse1 !== 16'h0) begin failures++; $display("FAIL rst_abort_pulse got=%h required=0000", wr_pulse1); end
    checks++; if (reg_out1[64 +: 32] !== 32'h0) begin failures++; $display("FAIL rst_abort_reg2 got=%h required=00000000", reg_out1[64 +: 32]); end
    $display("xfer dut1 WR addr=00000008 aborted by reset");
  endtask

  initial begin
    test_reset();
    test_byte_strobe();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_psel_abort();
    test_reset_abort();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
